// File: rtl/tl_tx_credit_gate.sv
// Transmit TL credit gate: checks flow-control credits and retry space, then streams one TLP to the DLL.
// Optional build macro INFINITE_CREDIT_EN: a zero limit at the first update marks that credit type infinite.
module tl_tx_credit_gate #(
    parameter int PIPE_DATA_WIDTH = 256,
    parameter int RETRY_DEPTH_LG2 = 8,
    parameter int CREDIT_DEPTH    = 12
) (
    input  logic                         sclk,
    input  logic                         srst_n,
    input  logic                         hdr_valid_i,
    output logic                         hdr_ready_o,
    input  logic [1:0]                   hdr_type_i,
    input  logic [9:0]                   hdr_len_dw_i,
    input  logic [PIPE_DATA_WIDTH-1:0]   hdr_data_i,
    input  logic                         pld_valid_i,
    output logic                         pld_ready_o,
    input  logic [PIPE_DATA_WIDTH-1:0]   pld_data_i,
    input  logic [CREDIT_DEPTH-1:0]      ep_cl_p_h_i,
    input  logic [CREDIT_DEPTH-1:0]      ep_cl_p_d_i,
    input  logic [CREDIT_DEPTH-1:0]      ep_cl_np_h_i,
    input  logic [CREDIT_DEPTH-1:0]      ep_cl_cpl_h_i,
    input  logic [CREDIT_DEPTH-1:0]      ep_cl_cpl_d_i,
    input  logic                         ep_cl_en_i,
    input  logic [RETRY_DEPTH_LG2+2:0]   retry_buffer_leftover_cnt_i,
    output logic [CREDIT_DEPTH-1:0]      cc_p_h_o,
    output logic [CREDIT_DEPTH-1:0]      cc_p_d_o,
    output logic [CREDIT_DEPTH-1:0]      cc_np_h_o,
    output logic [CREDIT_DEPTH-1:0]      cc_cpl_h_o,
    output logic [CREDIT_DEPTH-1:0]      cc_cpl_d_o,
    output logic [PIPE_DATA_WIDTH-1:0]   tl2dll_data_o,
    output logic [2:0]                   tl2dll_en_o,
    output logic                         blocked_o
);
    localparam int LW = RETRY_DEPTH_LG2 + 3;
    localparam int RW = (LW > 12) ? LW : 12;
    localparam logic [1:0] T_P   = 2'b00;
    localparam logic [1:0] T_NP  = 2'b01;
    localparam logic [1:0] T_CPL = 2'b10;
    localparam logic [CREDIT_DEPTH-1:0] CRED_ZERO = {CREDIT_DEPTH{1'b0}};
    localparam logic [CREDIT_DEPTH-1:0] CRED_ONE  = {{(CREDIT_DEPTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_HDR   = 3'd2,
        ST_DATA  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                      state_r;
    logic [1:0]                  type_r;
    logic [PIPE_DATA_WIDTH-1:0]  beat_r;
    logic [CREDIT_DEPTH-1:0]     dcred_r;
    logic [7:0]                  beats_r;
    logic [11:0]                 rneed_r;
    logic [CREDIT_DEPTH-1:0]     cl_p_h_r, cl_p_d_r, cl_np_h_r, cl_cpl_h_r, cl_cpl_d_r;
    logic                        cl_valid_r;
    logic [CREDIT_DEPTH-1:0]     cc_p_h_r, cc_p_d_r, cc_np_h_r, cc_cpl_h_r, cc_cpl_d_r;
`ifdef INFINITE_CREDIT_EN
    logic                        inf_p_h_r, inf_p_d_r, inf_np_h_r, inf_cpl_h_r, inf_cpl_d_r;
`endif

    logic [10:0]                 len_s;
    logic [7:0]                  beats_s;
    logic [CREDIT_DEPTH-1:0]     dcred_s;
    logic [11:0]                 rneed_s;
    logic [CREDIT_DEPTH-1:0]     hdr_cl_s, hdr_cc_s, dat_cl_s, dat_cc_s;
    logic                        hdr_inf_s, dat_inf_s, hdr_ok_s, dat_ok_s, retry_ok_s, pass_s;

    // Credits are modulo 2^CREDIT_DEPTH; a need fits when the wrapped remainder is non-negative.
    function automatic logic credit_ok(input logic [CREDIT_DEPTH-1:0] cl,
                                       input logic [CREDIT_DEPTH-1:0] cc,
                                       input logic [CREDIT_DEPTH-1:0] need);
        logic [CREDIT_DEPTH-1:0] diff;
        diff = cl - (cc + need);
        return ~diff[CREDIT_DEPTH-1];
    endfunction

    // Per-TLP data credits, payload beats and retry need from the offered header.
    always_comb begin
        len_s = (hdr_len_dw_i == 10'd0) ? 11'd1024 : {1'b0, hdr_len_dw_i};
        if ((hdr_type_i == T_P) || (hdr_type_i == T_CPL)) begin
            beats_s = 8'((len_s + 11'd7) >> 3'd3);
            dcred_s = CREDIT_DEPTH'((len_s + 11'd3) >> 3'd2);
        end else begin
            beats_s = 8'd0;
            dcred_s = CRED_ZERO;
        end
        rneed_s = {({1'b0, beats_s} + 9'd1), 3'b000};
    end

    // Credit and retry-space check for the TLP waiting in CHECK.
    always_comb begin
        hdr_cl_s  = cl_p_h_r;
        hdr_cc_s  = cc_p_h_r;
        dat_cl_s  = cl_p_d_r;
        dat_cc_s  = cc_p_d_r;
        hdr_inf_s = 1'b0;
        dat_inf_s = 1'b0;
        case (type_r)
            T_P: begin
`ifdef INFINITE_CREDIT_EN
                hdr_inf_s = inf_p_h_r;
                dat_inf_s = inf_p_d_r;
`endif
            end
            T_NP: begin
                hdr_cl_s = cl_np_h_r;
                hdr_cc_s = cc_np_h_r;
                dat_cl_s = CRED_ZERO;
                dat_cc_s = CRED_ZERO;
`ifdef INFINITE_CREDIT_EN
                hdr_inf_s = inf_np_h_r;
`endif
            end
            T_CPL: begin
                hdr_cl_s = cl_cpl_h_r;
                hdr_cc_s = cc_cpl_h_r;
                dat_cl_s = cl_cpl_d_r;
                dat_cc_s = cc_cpl_d_r;
`ifdef INFINITE_CREDIT_EN
                hdr_inf_s = inf_cpl_h_r;
                dat_inf_s = inf_cpl_d_r;
`endif
            end
            default: begin
                hdr_cl_s = cl_p_h_r;
            end
        endcase
        hdr_ok_s   = credit_ok(hdr_cl_s, hdr_cc_s, CRED_ONE);
        dat_ok_s   = credit_ok(dat_cl_s, dat_cc_s, dcred_r);
        retry_ok_s = RW'(retry_buffer_leftover_cnt_i) >= RW'(rneed_r);
        pass_s     = cl_valid_r & (hdr_ok_s | hdr_inf_s) & (dat_ok_s | dat_inf_s) & retry_ok_s;
    end

    // Credit limit capture; the first update after reset also fixes the infinite flags.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            cl_p_h_r   <= CRED_ZERO;
            cl_p_d_r   <= CRED_ZERO;
            cl_np_h_r  <= CRED_ZERO;
            cl_cpl_h_r <= CRED_ZERO;
            cl_cpl_d_r <= CRED_ZERO;
            cl_valid_r <= 1'b0;
`ifdef INFINITE_CREDIT_EN
            inf_p_h_r   <= 1'b0;
            inf_p_d_r   <= 1'b0;
            inf_np_h_r  <= 1'b0;
            inf_cpl_h_r <= 1'b0;
            inf_cpl_d_r <= 1'b0;
`endif
        end else if (ep_cl_en_i) begin
            cl_p_h_r   <= ep_cl_p_h_i;
            cl_p_d_r   <= ep_cl_p_d_i;
            cl_np_h_r  <= ep_cl_np_h_i;
            cl_cpl_h_r <= ep_cl_cpl_h_i;
            cl_cpl_d_r <= ep_cl_cpl_d_i;
            cl_valid_r <= 1'b1;
`ifdef INFINITE_CREDIT_EN
            if (!cl_valid_r) begin
                inf_p_h_r   <= (ep_cl_p_h_i == CRED_ZERO);
                inf_p_d_r   <= (ep_cl_p_d_i == CRED_ZERO);
                inf_np_h_r  <= (ep_cl_np_h_i == CRED_ZERO);
                inf_cpl_h_r <= (ep_cl_cpl_h_i == CRED_ZERO);
                inf_cpl_d_r <= (ep_cl_cpl_d_i == CRED_ZERO);
            end
`endif
        end
    end

    // TLP sequencing and consumed-credit accounting; beat_r holds the header, then the last payload beat.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_r    <= ST_IDLE;
            type_r     <= 2'b00;
            beat_r     <= {PIPE_DATA_WIDTH{1'b0}};
            dcred_r    <= CRED_ZERO;
            beats_r    <= 8'd0;
            rneed_r    <= 12'd0;
            cc_p_h_r   <= CRED_ZERO;
            cc_p_d_r   <= CRED_ZERO;
            cc_np_h_r  <= CRED_ZERO;
            cc_cpl_h_r <= CRED_ZERO;
            cc_cpl_d_r <= CRED_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hdr_valid_i) begin
                        beat_r  <= hdr_data_i;
                        type_r  <= hdr_type_i;
                        dcred_r <= dcred_s;
                        beats_r <= beats_s;
                        rneed_r <= rneed_s;
                        state_r <= (hdr_type_i == 2'b11) ? ST_IDLE : ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (pass_s) begin
                        case (type_r)
                            T_P: begin
                                cc_p_h_r <= cc_p_h_r + CRED_ONE;
                                cc_p_d_r <= cc_p_d_r + dcred_r;
                            end
                            T_NP:    cc_np_h_r <= cc_np_h_r + CRED_ONE;
                            T_CPL: begin
                                cc_cpl_h_r <= cc_cpl_h_r + CRED_ONE;
                                cc_cpl_d_r <= cc_cpl_d_r + dcred_r;
                            end
                            default: cc_p_h_r <= cc_p_h_r;
                        endcase
                        state_r <= ST_HDR;
                    end
                end
                ST_HDR:  state_r <= (beats_r != 8'd0) ? ST_DATA : ST_DONE;
                ST_DATA: begin
                    if (pld_valid_i) begin
                        beat_r  <= pld_data_i;
                        beats_r <= beats_r - 8'd1;
                        if (beats_r == 8'd1) begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Bus drive decoded from registered state; payload beats pass straight through while in DATA.
    always_comb begin
        tl2dll_en_o   = 3'b000;
        tl2dll_data_o = {PIPE_DATA_WIDTH{1'b0}};
        case (state_r)
            ST_HDR: begin
                tl2dll_data_o = beat_r;
                case (type_r)
                    T_P:     tl2dll_en_o = 3'b001;
                    T_NP:    tl2dll_en_o = 3'b011;
                    T_CPL:   tl2dll_en_o = 3'b101;
                    default: tl2dll_en_o = 3'b000;
                endcase
            end
            ST_DATA: begin
                if (pld_valid_i) begin
                    tl2dll_en_o   = (type_r == T_CPL) ? 3'b110 : 3'b010;
                    tl2dll_data_o = pld_data_i;
                end else begin
                    tl2dll_data_o = beat_r;
                end
            end
            ST_DONE: tl2dll_en_o = 3'b111;
            default: tl2dll_en_o = 3'b000;
        endcase
    end

    assign hdr_ready_o = (state_r == ST_IDLE) & hdr_valid_i;
    assign pld_ready_o = (state_r == ST_DATA);
    assign blocked_o   = (state_r == ST_CHECK) & ~pass_s;
    assign cc_p_h_o    = cc_p_h_r;
    assign cc_p_d_o    = cc_p_d_r;
    assign cc_np_h_o   = cc_np_h_r;
    assign cc_cpl_h_o  = cc_cpl_h_r;
    assign cc_cpl_d_o  = cc_cpl_d_r;

endmodule

// File: doc/tl_tx_credit_gate.md
Name: tl_tx_credit_gate

Overview:
Transmit-side transaction-layer stage directly upstream of the DLL write path. It accepts one TLP at a time (header plus optional payload beats) from the TL request source, checks it against the flow-control credit limits and consumed counts from the DLL receive path, and checks retry-buffer space. It then streams the TLP onto the 256-bit TL→DLL bus with the 3-bit beat-type encoding. It owns the consumed-credit counters (cc_*) fed back into the DLL.

Parameters:
PIPE_DATA_WIDTH, 256, TL→DLL beat width (8 DW per beat)
RETRY_DEPTH_LG2, 8, log2 of retry buffer depth; sets leftover-count width
CREDIT_DEPTH, 12, credit counter width (PCIe modulo-4096 arithmetic)

Ports:
sclk  in  1  clock
srst_n  in  1  asynchronous active-low reset
hdr_valid_i  in  1  TLP header offered
hdr_ready_o  out  1  header accepted this cycle
hdr_type_i  in  2  00 P, 01 NP, 10 CPL, 11 reserved (dropped)
hdr_len_dw_i  in  10  payload length in DW; 0 = 1024
hdr_data_i  in  PIPE_DATA_WIDTH  header beat
pld_valid_i  in  1  payload beat offered
pld_ready_o  out  1  payload beat accepted
pld_data_i  in  PIPE_DATA_WIDTH  payload beat
ep_cl_p_h_i, ep_cl_p_d_i, ep_cl_np_h_i, ep_cl_cpl_h_i, ep_cl_cpl_d_i  in  CREDIT_DEPTH each  credit limits
ep_cl_en_i  in  1  latch all five limits
retry_buffer_leftover_cnt_i  in  RETRY_DEPTH_LG2+3  free retry space in DW
cc_p_h_o, cc_p_d_o, cc_np_h_o, cc_cpl_h_o, cc_cpl_d_o  out  CREDIT_DEPTH each  credits consumed
tl2dll_data_o  out  PIPE_DATA_WIDTH  beat to DLL
tl2dll_en_o  out  3  000 IDLE, 001 P_HDR, 010 P_DATA, 011 NP_HDR, 101 CPL_HDR, 110 CPL_DATA, 111 DONE
blocked_o  out  1  high while in CHECK and the check fails

Behaviour:
- Reset (async, any state): FSM→IDLE; all outputs 0; cc counters 0; limit registers 0; cl_valid flag 0.
- Limits: every cycle with ep_cl_en_i=1, latch all five limits and set cl_valid. The check fails unconditionally while cl_valid=0.
- Derived per TLP, registered at acceptance:
  - L = len (0→1024).
  - Data credits D = ceil(L/4) for P/CPL; 0 for NP.
  - Payload beats B = ceil(L/8) for P/CPL; 0 for NP.
  - Retry need R = 8*(1+B) DW.
- Credit check, per type, for header need 1 and data need D: pass iff MSB of (CL − (CC + need)) mod 2^CREDIT_DEPTH is 0.
- FSM:
  - IDLE: hdr_ready_o=1 (combinational on hdr_valid_i). On accept, latch header, type and derived values. Type 11 is accepted and discarded, staying in IDLE. Otherwise go to CHECK.
  - CHECK: evaluate header credit, data credit and retry-buffer check (leftover ≥ R), all against the current cycle's values.
    - All pass: add 1 to the header cc and D to the data cc (modulo wrap; visible next cycle), then go to HDR.
    - Any fail: stay in CHECK with blocked_o=1; re-evaluate every cycle.
  - HDR: one cycle. tl2dll_data_o=header; tl2dll_en_o=001/011/101 by type. Go to DATA if B>0, else DONE.
  - DATA: pld_ready_o=1. Each pld_valid_i cycle outputs the beat with 010/110 and decrements the beat counter. With pld_valid_i=0, en=000 and data held. After the B-th beat, go to DONE.
  - DONE: one cycle, en=111, data 0. Then IDLE.
- Outputs tl2dll_* are driven combinationally from registered state/data.
- Minimum TLP: accept→CHECK→HDR→DONE, so first header on the bus 2 cycles after hdr_valid_i/hdr_ready_o.
- Back-to-back: a new header is accepted on the cycle after DONE.
- Excess pld_valid_i outside DATA is ignored (pld_ready_o=0).
- Limit updates during HDR/DATA do not affect the TLP in flight.

Optional Feature:
INFINITE_CREDIT_EN:
- When defined: the first ep_cl_en_i after reset records, per credit type, whether the latched limit is 0. A type recorded as 0 is infinite: its check always passes (cc still increments). Later updates do not change the infinite flags.
- When undefined: 0 is an ordinary limit value and no flags exist.

Test Plan:
- No ep_cl_en_i after reset; P TLP len 4 → stuck in CHECK, blocked_o=1, en stays 000, cc_p_h_o=0.
- CL p_h=2, p_d=8; P len 16 → en 001, 010, 010, 111 on consecutive cycles; cc_p_h_o=1, cc_p_d_o=4.
- NP len 1 with np_h CL=1 → 011 then 111; cc_np_h_o=1; no pld_ready_o.
- leftover=15, CPL len 8 (R=16) → blocked; leftover raised to 16 → proceeds; pld_valid_i gap mid-payload gives en=000 bubble.
- cc_p_d at 4094, CL=2 (mod), P len 16 (D=4) → passes; cc_p_d_o wraps to 2.
- Assert srst_n low during DATA → all outputs 0 immediately; after release a new TLP starts cleanly. With INFINITE_CREDIT_EN, CL p_h=0 at first update → P TLPs pass indefinitely.
